serial_addsub_ctrl: RTL and testbench

//  Bit-serial sequencer that shares one external 1-bit add/subtract cell across WIDTH-bit operands.
//  On start it latches operands and mode, feeds the cell one bit per cycle (LSB first), and recirculates the carry.
//  It assembles the result and reports carry and signed overflow. Sits between a host issuing add/sub ops and the mux-based add/sub cell.

---
 rtl/serial_addsub_ctrl.sv | 167 ++++++++++++++++
 tb/tb_serial_addsub_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_addsub_ctrl.sv
// serial_addsub_ctrl: bit-serial add/subtract sequencer driving an external
// 1-bit add/sub cell. Operands are fed LSB first, the cell's carry is
// recirculated, and the result, final carry and signed overflow are
// collected after WIDTH bit cycles.
// Optional feature macro: SERIAL_ADDSUB_FLAGS_EN adds the zero/negative flags.
module serial_addsub_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sel,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             bit_a,
   output logic             bit_b,
   output logic             bit_cin,
   output logic             bit_sel,
   input  logic             bit_sum,
   input  logic             bit_cout,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             cout,
`ifdef SERIAL_ADDSUB_FLAGS_EN
   output logic             zero,
   output logic             negative,
`endif
   output logic             overflow
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nx;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-2:0] res_sh;
   logic [WIDTH-1:0] res_next;
   logic             carry;
   logic             sel_q;
   logic [CW-1:0]    cnt;
   logic             accept;
   logic             last_bit;

   // Control decode: new op acceptance, final bit cycle, and next state.
   always_comb begin
      state_nx = state;
      accept   = 1'b0;
      last_bit = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               accept   = 1'b1;
               state_nx = S_RUN;
            end else begin
               state_nx = S_IDLE;
            end
         end
         S_RUN: begin
            if (cnt == LAST) begin
               last_bit = 1'b1;
               state_nx = S_DONE;
            end else begin
               state_nx = S_RUN;
            end
         end
         S_DONE: begin
            if (start) begin
               accept   = 1'b1;
               state_nx = S_RUN;
            end else begin
               state_nx = S_IDLE;
            end
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

   // State register; reset aborts any operation in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Cell interface and status: operand bits only driven while running.
   always_comb begin
      bit_a   = 1'b0;
      bit_b   = 1'b0;
      bit_cin = 1'b0;
      bit_sel = sel_q;
      busy    = (state == S_RUN);
      done    = (state == S_DONE);
      if (state == S_RUN) begin
         bit_a   = a_sh[0];
         bit_b   = b_sh[0];
         bit_cin = carry;
      end else begin
         bit_a   = 1'b0;
         bit_b   = 1'b0;
         bit_cin = 1'b0;
      end
   end

   // Incoming sum bit enters at the MSB; after WIDTH shifts it is aligned.
   assign res_next = {bit_sum, res_sh};

   // Datapath: operand shifters, carry recirculation, result capture.
   // The carry register holds the carry into the MSB on the last bit cycle,
   // so overflow is that carry XOR the cell's final carry out.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_sh     <= '0;
         b_sh     <= '0;
         res_sh   <= '0;
         carry    <= 1'b0;
         sel_q    <= 1'b0;
         cnt      <= '0;
         result   <= '0;
         cout     <= 1'b0;
         overflow <= 1'b0;
`ifdef SERIAL_ADDSUB_FLAGS_EN
         zero     <= 1'b0;
         negative <= 1'b0;
`endif
      end else if (accept) begin
         a_sh   <= a;
         b_sh   <= b;
         res_sh <= '0;
         sel_q  <= sel;
         carry  <= sel;
         cnt    <= '0;
      end else if (state == S_RUN) begin
         a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
         b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
         res_sh <= res_next[WIDTH-1:1];
         carry  <= bit_cout;
         cnt    <= cnt + CW'(1);
         if (last_bit) begin
            result   <= res_next;
            cout     <= bit_cout;
            overflow <= carry ^ bit_cout;
`ifdef SERIAL_ADDSUB_FLAGS_EN
            zero     <= (res_next == '0);
            negative <= res_next[WIDTH-1];
`endif
         end else begin
            result   <= result;
         end
      end else begin
         cnt <= cnt;
      end
   end

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Self-checking bench for serial_addsub_ctrl (WIDTH=8). The 1-bit cell is
// modelled here; an arithmetic reference model predicts every output each
// cycle, and directed operations are pinned with hand-computed literals.
module tb_serial_addsub_ctrl;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic         sel;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         bit_a, bit_b, bit_cin, bit_sel, bit_sum, bit_cout;
   logic         busy, done, cout, overflow;
   logic [W-1:0] result;
`ifdef SERIAL_ADDSUB_FLAGS_EN
   logic         zero, negative;
`endif

   int n_vec = 0;
   int n_err = 0;

   serial_addsub_ctrl #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .sel(sel), .a(a), .b(b),
      .bit_a(bit_a), .bit_b(bit_b), .bit_cin(bit_cin), .bit_sel(bit_sel),
      .bit_sum(bit_sum), .bit_cout(bit_cout),
      .busy(busy), .done(done), .result(result), .cout(cout),
`ifdef SERIAL_ADDSUB_FLAGS_EN
      .zero(zero), .negative(negative),
`endif
      .overflow(overflow)
   );

   always #5 clk = ~clk;

   // external mux-based add/sub cell
   assign bit_sum  = bit_a ^ (bit_b ^ bit_sel) ^ bit_cin;
   assign bit_cout = (bit_a & (bit_b ^ bit_sel)) | (bit_a & bit_cin) | ((bit_b ^ bit_sel) & bit_cin);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // reference arithmetic: returns {overflow, carry, result}
   function automatic logic [W+1:0] op_model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
      int sx, sy, r;
      logic c, v;
      sx = $signed(x);
      sy = $signed(y);
      if (s) begin
         r = sx - sy;
         c = (x >= y);
      end else begin
         r = sx + sy;
         c = (int'(x) + int'(y)) > 255;
      end
      v = (r > 127) || (r < -128);
      return {v, c, r[W-1:0]};
   endfunction

   // carry entering bit position k of the operation
   function automatic logic carry_into(input logic [W-1:0] x, input logic [W-1:0] y, input logic s, input int k);
      int m, lo;
      logic [W-1:0] ny;
      ny = ~y;
      m  = (1 << k) - 1;
      if (s) lo = (int'(x) & m) + (int'(ny) & m) + 1;
      else   lo = (int'(x) & m) + (int'(y) & m);
      return lo[k];
   endfunction

   // reference model state
   int           m_left = 0;
   logic         m_done = 1'b0;
   logic [W-1:0] m_a = '0, m_b = '0, m_res = '0;
   logic         m_sel = 1'b0, m_cout = 1'b0, m_ovf = 1'b0;
   logic [W+1:0] m_tmp;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_left <= 0; m_done <= 1'b0; m_a <= '0; m_b <= '0; m_sel <= 1'b0;
         m_res <= '0; m_cout <= 1'b0; m_ovf <= 1'b0;
      end else if (m_left == 0) begin
         m_done <= 1'b0;
         if (start) begin
            m_left <= W; m_a <= a; m_b <= b; m_sel <= sel;
         end
      end else begin
         m_left <= m_left - 1;
         if (m_left == 1) begin
            m_tmp = op_model(m_a, m_b, m_sel);
            m_done <= 1'b1;
            m_res  <= m_tmp[W-1:0];
            m_cout <= m_tmp[W];
            m_ovf  <= m_tmp[W+1];
         end
      end
   end

   // per-cycle comparison against the model
   always @(negedge clk) begin
      int k;
      chk("busy", 32'(busy), 32'(m_left > 0));
      chk("done", 32'(done), 32'(m_done));
      chk("result", 32'(result), 32'(m_res));
      chk("cout", 32'(cout), 32'(m_cout));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("bit_sel", 32'(bit_sel), 32'(m_sel));
`ifdef SERIAL_ADDSUB_FLAGS_EN
      chk("zero", 32'(zero), 32'(m_res == '0));
      chk("negative", 32'(negative), 32'(m_res[W-1]));
`endif
      if (m_left > 0) begin
         k = W - m_left;
         chk("bit_a", 32'(bit_a), 32'(m_a[k]));
         chk("bit_b", 32'(bit_b), 32'(m_b[k]));
         chk("bit_cin", 32'(bit_cin), 32'(carry_into(m_a, m_b, m_sel, k)));
      end else begin
         chk("bit_a_idle", 32'(bit_a), 32'd0);
         chk("bit_b_idle", 32'(bit_b), 32'd0);
         chk("bit_cin_idle", 32'(bit_cin), 32'd0);
      end
   end

   // present an op for one edge, then scramble inputs to prove latching
   task automatic issue(input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
      start = 1'b1; sel = s; a = x; b = y;
      @(posedge clk); #1;
      start = 1'b0; sel = ~s; a = ~x; b = ~y;
   endtask

   // wait (bounded) for done; lat = edges after accept, nb = busy samples
   task automatic wait_done(output int lat, output int nb);
      logic got;
      got = 1'b0; lat = 0; nb = busy ? 1 : 0;
      for (int i = 1; i <= 20 && !got; i++) begin
         @(posedge clk); #1;
         if (done) begin
            got = 1'b1; lat = i;
         end else begin
            nb += busy ? 1 : 0;
         end
      end
      chk("done_seen", 32'(got), 32'd1);
   endtask

   task automatic expect_res(input string name, input logic [W-1:0] r, input logic c, input logic v);
      chk({name, "_result"}, 32'(result), 32'(r));
      chk({name, "_cout"}, 32'(cout), 32'(c));
      chk({name, "_ovf"}, 32'(overflow), 32'(v));
   endtask

   int lat, nb;

   initial begin
      rst = 1'b1; start = 1'b0; sel = 1'b0; a = '0; b = '0;
      #12;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_result", 32'(result), 32'd0);
      chk("rst_bits", 32'({bit_a, bit_b, bit_cin, bit_sel}), 32'd0);
      #10 rst = 1'b0;
      @(posedge clk); #1;

      // 1: add with latency and busy-length check
      issue(1'b0, 8'h3C, 8'h15);
      wait_done(lat, nb);
      chk("t1_latency", 32'(lat), 32'd8);
      chk("t1_busy_cycles", 32'(nb), 32'd8);
      expect_res("t1", 8'h51, 1'b0, 1'b0);

      // 2: signed overflow on add
      issue(1'b0, 8'h7F, 8'h01);
      wait_done(lat, nb);
      expect_res("t2", 8'h80, 1'b0, 1'b1);
`ifdef SERIAL_ADDSUB_FLAGS_EN
      chk("t2_zero", 32'(zero), 32'd0);
      chk("t2_negative", 32'(negative), 32'd1);
`endif

      // 3: subtract with borrow, then subtract with overflow
      issue(1'b1, 8'h10, 8'h20);
      wait_done(lat, nb);
      expect_res("t3a", 8'hF0, 1'b0, 1'b0);
      issue(1'b1, 8'h80, 8'h01);
      wait_done(lat, nb);
      expect_res("t3b", 8'h7F, 1'b1, 1'b1);

      // 6: equal operands subtract to zero
      issue(1'b1, 8'h55, 8'h55);
      wait_done(lat, nb);
      expect_res("t6", 8'h00, 1'b1, 1'b0);
`ifdef SERIAL_ADDSUB_FLAGS_EN
      chk("t6_zero", 32'(zero), 32'd1);
      chk("t6_negative", 32'(negative), 32'd0);
`endif
      repeat (2) @(posedge clk);
      #1;

      // 4: start mid-run ignored; start in DONE chains with no idle cycle
      issue(1'b0, 8'h3C, 8'h15);
      repeat (3) @(posedge clk);
      #1;
      start = 1'b1; a = 8'hFF; b = 8'hFF; sel = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(lat, nb);
      expect_res("t4a", 8'h51, 1'b0, 1'b0);
      start = 1'b1; sel = 1'b0; a = 8'h22; b = 8'h11;
      @(posedge clk); #1;
      start = 1'b0;
      chk("t4_b2b_busy", 32'(busy), 32'd1);
      wait_done(lat, nb);
      chk("t4_b2b_latency", 32'(lat), 32'd8);
      expect_res("t4b", 8'h33, 1'b0, 1'b0);

      // 5: async reset at run cycle 4 aborts the op
      issue(1'b0, 8'hA5, 8'h0F);
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("t5_busy", 32'(busy), 32'd0);
      chk("t5_result", 32'(result), 32'd0);
      chk("t5_bits", 32'({bit_a, bit_b, bit_cin, bit_sel}), 32'd0);
      @(posedge clk); #3 rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         chk("t5_no_done", 32'(done), 32'd0);
      end
      issue(1'b0, 8'h01, 8'h01);
      wait_done(lat, nb);
      expect_res("t5", 8'h02, 1'b0, 1'b0);

      repeat (3) @(posedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
